rc4_encryptor: RTL

Encrypts a plaintext message with RC4 under a given 24-bit key. It writes the ciphertext into the encrypted-message memory that the codebreaking FSM later cracks, so it is the producer end of that interface.
- Runs the same three phases as the cracker against a 256x8 working-memory RAM (S): S init, key schedule, keystream generation.
- Reads plaintext from a 32x8 ROM; writes ciphertext to a 32x8 RAM.

---
 rtl/rc4_encryptor.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rc4_encryptor.sv
// RC4 encryptor: S init, key schedule and keystream XOR of a plaintext ROM into a ciphertext RAM.
// Optional build macro RC4_PLAINTEXT_CHECK_EN adds bad_char and stops on non [a-z ] plaintext.
module rc4_encryptor #(
  parameter int MESSAGE_LENGTH = 32,
  parameter int KEY_LENGTH     = 3,
  parameter int MSG_ADDR_W     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [8*KEY_LENGTH-1:0] key,
  input  logic [7:0]              q_s,
  input  logic [7:0]              q_p,
  output logic [7:0]              address_s,
  output logic [7:0]              data_s,
  output logic                    wren_s,
  output logic [MSG_ADDR_W-1:0]   address_p,
  output logic [MSG_ADDR_W-1:0]   address_e,
  output logic [7:0]              data_e,
  output logic                    wren_e,
  output logic                    busy,
`ifdef RC4_PLAINTEXT_CHECK_EN
  output logic                    bad_char,
`endif
  output logic                    done
);

  localparam int KEY_W = 8 * KEY_LENGTH;
  localparam logic [MSG_ADDR_W-1:0] LAST_K = MSG_ADDR_W'(MESSAGE_LENGTH - 1);

  typedef enum logic [4:0] {
    IDLE, INIT_S,
    KSA_RD_I, KSA_WAIT_I, KSA_J, KSA_WAIT_J, KSA_WR_J, KSA_WR_I,
    PRGA_RD_I, PRGA_WAIT_I, PRGA_J, PRGA_WAIT_J, PRGA_WR_J, PRGA_WR_I,
    PRGA_RD_F, PRGA_WAIT_F, PRGA_WR_E, DONE
  } state_t;

  state_t                  state_r, state_nxt_s;
  logic [7:0]              i_r, i_nxt_s;
  logic [7:0]              j_r, j_nxt_s;
  logic [MSG_ADDR_W-1:0]   k_r, k_nxt_s;
  logic [7:0]              si_r, si_nxt_s;
  logic [7:0]              sj_r, sj_nxt_s;
  logic [KEY_W-1:0]        key_r, key_nxt_s;
  logic [7:0]              address_s_nxt_s, data_s_nxt_s, data_e_nxt_s;
  logic [MSG_ADDR_W-1:0]   address_p_nxt_s, address_e_nxt_s;
  logic                    wren_s_nxt_s, wren_e_nxt_s, busy_nxt_s, done_nxt_s;
  logic                    accept_s;
  logic [7:0]              ksa_j_s, prga_j_s;

  // key_r rotates one byte per KSA step, so its top byte is always key[i mod KEY_LENGTH]
  assign ksa_j_s  = j_r + q_s + key_r[KEY_W-1 -: 8];
  assign prga_j_s = j_r + q_s;
  assign accept_s = start & ((state_r == IDLE) | ((state_r == DONE) & done));

`ifdef RC4_PLAINTEXT_CHECK_EN
  logic bad_char_nxt_s;

  function automatic logic is_plain_char(input logic [7:0] c);
    return ((c >= 8'h61) && (c <= 8'h7A)) || (c == 8'h20);
  endfunction
`endif

  // Next-state and next-output logic for the three RC4 phases
  always_comb begin
    state_nxt_s     = state_r;
    i_nxt_s         = i_r;
    j_nxt_s         = j_r;
    k_nxt_s         = k_r;
    si_nxt_s        = si_r;
    sj_nxt_s        = sj_r;
    key_nxt_s       = key_r;
    address_s_nxt_s = address_s;
    data_s_nxt_s    = data_s;
    wren_s_nxt_s    = 1'b0;
    address_p_nxt_s = address_p;
    address_e_nxt_s = address_e;
    data_e_nxt_s    = data_e;
    wren_e_nxt_s    = 1'b0;
    busy_nxt_s      = busy;
    done_nxt_s      = done;
`ifdef RC4_PLAINTEXT_CHECK_EN
    bad_char_nxt_s  = bad_char;
`endif
    if (accept_s) begin
      key_nxt_s   = key;
      busy_nxt_s  = 1'b1;
      done_nxt_s  = 1'b0;
      i_nxt_s     = 8'd0;
      j_nxt_s     = 8'd0;
      k_nxt_s     = '0;
`ifdef RC4_PLAINTEXT_CHECK_EN
      bad_char_nxt_s = 1'b0;
`endif
      state_nxt_s = INIT_S;
    end else begin
      case (state_r)
        IDLE: state_nxt_s = IDLE;
        INIT_S: begin
          address_s_nxt_s = i_r;
          data_s_nxt_s    = i_r;
          wren_s_nxt_s    = 1'b1;
          i_nxt_s         = i_r + 8'd1;
          if (i_r == 8'd255) begin
            j_nxt_s     = 8'd0;
            state_nxt_s = KSA_RD_I;
          end else begin
            state_nxt_s = INIT_S;
          end
        end
        KSA_RD_I: begin
          address_s_nxt_s = i_r;
          state_nxt_s     = KSA_WAIT_I;
        end
        KSA_WAIT_I: state_nxt_s = KSA_J;
        KSA_J: begin
          si_nxt_s        = q_s;
          j_nxt_s         = ksa_j_s;
          address_s_nxt_s = ksa_j_s;
          key_nxt_s       = {key_r[KEY_W-9:0], key_r[KEY_W-1 -: 8]};
          state_nxt_s     = KSA_WAIT_J;
        end
        KSA_WAIT_J: state_nxt_s = KSA_WR_J;
        KSA_WR_J: begin
          sj_nxt_s        = q_s;
          address_s_nxt_s = j_r;
          data_s_nxt_s    = si_r;
          wren_s_nxt_s    = 1'b1;
          state_nxt_s     = KSA_WR_I;
        end
        KSA_WR_I: begin
          address_s_nxt_s = i_r;
          data_s_nxt_s    = sj_r;
          wren_s_nxt_s    = 1'b1;
          if (i_r == 8'd255) begin
            i_nxt_s     = 8'd1;
            j_nxt_s     = 8'd0;
            k_nxt_s     = '0;
            state_nxt_s = PRGA_RD_I;
          end else begin
            i_nxt_s     = i_r + 8'd1;
            state_nxt_s = KSA_RD_I;
          end
        end
        PRGA_RD_I: begin
          address_s_nxt_s = i_r;
          state_nxt_s     = PRGA_WAIT_I;
        end
        PRGA_WAIT_I: state_nxt_s = PRGA_J;
        PRGA_J: begin
          si_nxt_s        = q_s;
          j_nxt_s         = prga_j_s;
          address_s_nxt_s = prga_j_s;
          state_nxt_s     = PRGA_WAIT_J;
        end
        PRGA_WAIT_J: state_nxt_s = PRGA_WR_J;
        PRGA_WR_J: begin
          sj_nxt_s        = q_s;
          address_s_nxt_s = j_r;
          data_s_nxt_s    = si_r;
          wren_s_nxt_s    = 1'b1;
          state_nxt_s     = PRGA_WR_I;
        end
        PRGA_WR_I: begin
          address_s_nxt_s = i_r;
          data_s_nxt_s    = sj_r;
          wren_s_nxt_s    = 1'b1;
          state_nxt_s     = PRGA_RD_F;
        end
        PRGA_RD_F: begin
          address_s_nxt_s = si_r + sj_r;
          address_p_nxt_s = k_r;
          state_nxt_s     = PRGA_WAIT_F;
        end
        PRGA_WAIT_F: state_nxt_s = PRGA_WR_E;
        PRGA_WR_E: begin
`ifdef RC4_PLAINTEXT_CHECK_EN
          if (!is_plain_char(q_p)) begin
            bad_char_nxt_s = 1'b1;
            busy_nxt_s     = 1'b0;
            done_nxt_s     = 1'b1;
            state_nxt_s    = DONE;
          end else
`endif
          begin
            address_e_nxt_s = k_r;
            data_e_nxt_s    = q_s ^ q_p;
            wren_e_nxt_s    = 1'b1;
            i_nxt_s         = i_r + 8'd1;
            k_nxt_s         = k_r + MSG_ADDR_W'(1);
            if (k_r == LAST_K) begin
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = PRGA_RD_I;
            end
          end
        end
        DONE: begin
          busy_nxt_s  = 1'b0;
          done_nxt_s  = 1'b1;
          state_nxt_s = DONE;
        end
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      i_r       <= 8'd0;
      j_r       <= 8'd0;
      k_r       <= '0;
      si_r      <= 8'd0;
      sj_r      <= 8'd0;
      key_r     <= '0;
      address_s <= 8'd0;
      data_s    <= 8'd0;
      wren_s    <= 1'b0;
      address_p <= '0;
      address_e <= '0;
      data_e    <= 8'd0;
      wren_e    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef RC4_PLAINTEXT_CHECK_EN
      bad_char  <= 1'b0;
`endif
    end else begin
      state_r   <= state_nxt_s;
      i_r       <= i_nxt_s;
      j_r       <= j_nxt_s;
      k_r       <= k_nxt_s;
      si_r      <= si_nxt_s;
      sj_r      <= sj_nxt_s;
      key_r     <= key_nxt_s;
      address_s <= address_s_nxt_s;
      data_s    <= data_s_nxt_s;
      wren_s    <= wren_s_nxt_s;
      address_p <= address_p_nxt_s;
      address_e <= address_e_nxt_s;
      data_e    <= data_e_nxt_s;
      wren_e    <= wren_e_nxt_s;
      busy      <= busy_nxt_s;
      done      <= done_nxt_s;
`ifdef RC4_PLAINTEXT_CHECK_EN
      bad_char  <= bad_char_nxt_s;
`endif
    end
  end

endmodule
